alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised WIDTH-bit ALU built as the multi-bit successor of the 1-bit ripple slice.
- Adds registered operands and result, a valid/ready handshake on input and output, zero/overflow/carry flags, and a correct signed set-less-than.
- An optional iterative shift-add multiplier takes WIDTH cycles.
- Sits between the register-file read stage and write-back in the class datapath.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 2).
- CNT_W, $clog2(WIDTH)+1, multiplier iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and opcode valid
- in_ready  output  1  block can accept an operation this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_op  input  3  operation select (see Behaviour)
- out_valid  output  1  result and flags valid
- out_ready  input  1  consumer accepts the result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- overflow  output  1  signed overflow (ADD/SUB); high-half-nonzero (MUL)
- carry  output  1  carry-out of the adder (ADD/SUB), else 0
- illegal  output  1  unsupported opcode was issued

Behaviour:
- Clock and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk.
  - In reset: state=IDLE, in_ready=0 during reset, out_valid=0; result, zero, overflow, carry, illegal all 0.
  - in_ready=1 from the first cycle after reset is released.
- Opcodes:
  - 000 AND.
  - 001 OR.
  - 010 ADD.
  - 110 SUB, computed as a + ~b + 1.
  - 111 SLT: result = {0…0, sum[WIDTH-1] ^ ovf}, with sum/ovf taken from SUB.
  - 100 NOR, computed as ~a & ~b.
  - 011 MUL (optional feature).
  - 101 illegal.
- Handshake: an operation is accepted when in_valid && in_ready.
- in_ready = (state==IDLE).
- FSM states IDLE, MUL, DONE:
  - IDLE, accept a non-MUL op: compute combinationally, register all outputs, go to DONE. Latency is 1 cycle (out_valid in the cycle after acceptance).
  - IDLE, accept MUL: latch a as multiplicand and b as multiplier, clear the accumulator, set count = 0, go to MUL.
  - MUL: each cycle, if multiplier LSB is 1, acc += multiplicand (2*WIDTH wide). Then shift multiplicand left, shift multiplier right, count++.
  - MUL exit: after WIDTH iterations go to DONE. result = acc[WIDTH-1:0]; overflow = |acc[2W-1:W]; carry=0. out_valid rises WIDTH+1 cycles after acceptance.
  - DONE: out_valid=1 and outputs held stable until out_ready. On out_valid && out_ready go to IDLE, clear out_valid.
- No bypass: a new op cannot be accepted in the same cycle the result is drained. Throughput is at most 1 op per 2 cycles.
- Flags:
  - zero is computed on the final result for every op.
  - overflow for ADD/SUB is (a_msb==b'_msb) && (sum_msb!=a_msb), where b' is b after inversion for SUB.
  - overflow and carry are 0 for logic ops and SLT.
- Illegal opcode: result=0, all flags 0 except zero=1, illegal=1. Takes the normal 1-cycle path to DONE.
- Inputs a, b, alu_op are ignored when in_ready=0.
- Reset mid-MUL or in DONE: the operation is dropped, all state clears, and no result is produced.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

Optional Feature:
- Macro name: ALU_SEQ_MUL_EN.
- Defined: opcode 011 runs the iterative multiplier as above. MUL state, accumulator and counter are synthesised.
- Undefined: MUL state, accumulator and counter are absent. Opcode 011 is treated as illegal (1-cycle, illegal=1, result=0). in_ready is asserted in IDLE only.

Decomposition:
- Package alu_seq_pkg holds:
  - the alu_op localparam codes (OP_AND, OP_OR, OP_ADD, OP_MUL, OP_NOR, OP_SUB, OP_SLT);
  - the state enum {S_IDLE, S_MUL, S_DONE}.
- One sub-module, alu_seq_core: the purely combinational WIDTH-bit logic/adder/SLT/flag unit. It is instantiated once. The FSM, registers and multiplier stay in alu_seq.

Test Plan:
- WIDTH=8. ADD a=0x7F, b=0x01, out_ready=1 -> out_valid 1 cycle later; result=0x80, overflow=1, carry=0, zero=0.
- SUB a=0x05, b=0x05 -> result=0x00, zero=1, carry=1, overflow=0. Then SLT a=0x80 (-128), b=0x7F -> result=0x01 (signed compare is correct despite the subtraction overflowing).
- MUL a=0x0F, b=0x11 (ALU_SEQ_MUL_EN defined) -> in_ready=0 for 9 cycles; out_valid at cycle 9 after accept; result=0xFF, overflow=0. Then MUL a=0x10, b=0x10 -> result=0x00, overflow=1, zero=1.
- Backpressure: hold out_ready=0 for 5 cycles after an AND (a=0xF0, b=0x3C) -> result=0x30 held stable, in_ready=0 throughout, and a new in_valid is ignored. Raising out_ready drains the result and in_ready returns the next cycle.
- Opcode 101, and opcode 011 with ALU_SEQ_MUL_EN undefined -> illegal=1, result=0, zero=1 after 1 cycle.
- Assert rst_n=0 for 1 cycle on the 4th cycle of a MUL -> next cycle state IDLE, out_valid=0, all outputs 0. No stale result ever appears.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the sequential ALU.
// Compile with ALU_SEQ_MUL_EN defined to enable the iterative multiplier.
package alu_seq_pkg;

   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_MUL = 3'b011;
   localparam logic [2:0] OP_NOR = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b110;
   localparam logic [2:0] OP_SLT = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_core.sv
// Combinational WIDTH-bit logic/adder/set-less-than unit with zero, overflow and carry flags.
// MUL and reserved opcodes come out as illegal here; the sequencer overrides MUL when enabled.
module alu_seq_core
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       op_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             overflow_o,
   output logic             carry_o,
   output logic             illegal_o
);

   logic             isSub;
   logic [WIDTH-1:0] bOperand;
   logic [WIDTH:0]   sumWide;
   logic [WIDTH-1:0] sum;
   logic             sumCarry;
   logic             sumOvf;

   // SUB and SLT share one adder path: a + ~b + 1.
   assign isSub    = (op_i == OP_SUB) || (op_i == OP_SLT);
   assign bOperand = isSub ? ~b_i : b_i;
   assign sumWide  = {1'b0, a_i} + {1'b0, bOperand} + {{WIDTH{1'b0}}, isSub};
   assign sum      = sumWide[WIDTH-1:0];
   assign sumCarry = sumWide[WIDTH];
   assign sumOvf   = (a_i[WIDTH-1] == bOperand[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

   always_comb begin
      result_o   = '0;
      overflow_o = 1'b0;
      carry_o    = 1'b0;
      illegal_o  = 1'b0;
      case (op_i)
         OP_AND: result_o = a_i & b_i;
         OP_OR:  result_o = a_i | b_i;
         OP_NOR: result_o = ~a_i & ~b_i;
         OP_ADD, OP_SUB: begin
            result_o   = sum;
            overflow_o = sumOvf;
            carry_o    = sumCarry;
         end
         // Sign of the difference corrected by overflow gives a true signed compare.
         OP_SLT: result_o = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ sumOvf};
         default: illegal_o = 1'b1;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: registered results behind a valid/ready handshake, optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build the WIDTH-cycle multiplier for opcode 011.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             carry,
   output logic             illegal
);

   if (WIDTH < 2 || CNT_W != $clog2(WIDTH) + 1) begin : gBadParam
      $error("alu_seq: WIDTH must be >= 2 and CNT_W must stay derived");
   end

   state_t           state_q;
   logic             inReady_q;
   logic             outValid_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q;
   logic             overflow_q;
   logic             carry_q;
   logic             illegal_q;

   logic [WIDTH-1:0] coreResult;
   logic             coreZero;
   logic             coreOverflow;
   logic             coreCarry;
   logic             coreIllegal;

   logic             accept;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplier_q;
   logic [CNT_W-1:0]   count_q;
   logic [2*WIDTH-1:0] acc_d;

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

   alu_seq_core #(.WIDTH(WIDTH)) uCore (
      .a_i        (a),
      .b_i        (b),
      .op_i       (alu_op),
      .result_o   (coreResult),
      .zero_o     (coreZero),
      .overflow_o (coreOverflow),
      .carry_o    (coreCarry),
      .illegal_o  (coreIllegal)
   );

   // in_ready is registered so it stays low for the whole reset cycle.
   assign accept = in_valid && inReady_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         inReady_q  <= 1'b0;
         outValid_q <= 1'b0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         overflow_q <= 1'b0;
         carry_q    <= 1'b0;
         illegal_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
         acc_q      <= '0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         count_q    <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               inReady_q <= 1'b1;
               if (accept) begin
                  inReady_q <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
                  if (alu_op == OP_MUL) begin
                     mcand_q  <= {{WIDTH{1'b0}}, a};
                     mplier_q <= b;
                     acc_q    <= '0;
                     count_q  <= '0;
                     state_q  <= S_MUL;
                  end else
`endif
                  begin
                     result_q   <= coreResult;
                     zero_q     <= coreZero;
                     overflow_q <= coreOverflow;
                     carry_q    <= coreCarry;
                     illegal_q  <= coreIllegal;
                     outValid_q <= 1'b1;
                     state_q    <= S_DONE;
                  end
               end
            end
`ifdef ALU_SEQ_MUL_EN
            // One shift-add step per cycle; the last step publishes the low half.
            S_MUL: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               count_q  <= count_q + 1'b1;
               if (count_q == CNT_W'(WIDTH - 1)) begin
                  result_q   <= acc_d[WIDTH-1:0];
                  zero_q     <= (acc_d[WIDTH-1:0] == '0);
                  overflow_q <= |acc_d[2*WIDTH-1:WIDTH];
                  carry_q    <= 1'b0;
                  illegal_q  <= 1'b0;
                  outValid_q <= 1'b1;
                  state_q    <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) begin
                  outValid_q <= 1'b0;
                  inReady_q  <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            default: begin
               outValid_q <= 1'b0;
               inReady_q  <= 1'b0;
               state_q    <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = inReady_q;
   assign out_valid = outValid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign overflow  = overflow_q;
   assign carry     = carry_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 with hand-computed expectations.
// Multiplier steps run only when ALU_SEQ_MUL_EN is defined; otherwise opcode 011 is checked as illegal.
module tb_alu_seq;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         inValid;
   logic         inReady;
   logic [W-1:0] aIn;
   logic [W-1:0] bIn;
   logic [2:0]   opIn;
   logic         outValid;
   logic         outReady;
   logic [W-1:0] resultOut;
   logic         zeroOut;
   logic         ovfOut;
   logic         carryOut;
   logic         illegalOut;

   int checks = 0;
   int errors = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (inValid),
      .in_ready  (inReady),
      .a         (aIn),
      .b         (bIn),
      .alu_op    (opIn),
      .out_valid (outValid),
      .out_ready (outReady),
      .result    (resultOut),
      .zero      (zeroOut),
      .overflow  (ovfOut),
      .carry     (carryOut),
      .illegal   (illegalOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one operation for a single edge, then drop in_valid.
   task automatic applyStimulus(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      opIn    = op;
      aIn     = av;
      bIn     = bv;
      inValid = 1'b1;
      @(posedge clk);
      #1;
      inValid = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkAll(input string tag, input logic [W-1:0] res, input logic z,
                           input logic o, input logic c, input logic il);
      checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
      checkOutput({tag, "_result"}, 32'(resultOut), 32'(res));
      checkOutput({tag, "_zero"}, 32'(zeroOut), 32'(z));
      checkOutput({tag, "_ovf"}, 32'(ovfOut), 32'(o));
      checkOutput({tag, "_carry"}, 32'(carryOut), 32'(c));
      checkOutput({tag, "_illegal"}, 32'(illegalOut), 32'(il));
   endtask

   initial begin
      int cycles;
      logic sawStale;
      rst_n    = 1'b0;
      inValid  = 1'b0;
      outReady = 1'b1;
      aIn      = '0;
      bIn      = '0;
      opIn     = 3'b000;

      // Reset state
      repeat (3) step();
      checkOutput("rst_in_ready", 32'(inReady), 32'd0);
      checkOutput("rst_out_valid", 32'(outValid), 32'd0);
      checkOutput("rst_result", 32'(resultOut), 32'd0);
      checkOutput("rst_flags", 32'({zeroOut, ovfOut, carryOut, illegalOut}), 32'd0);
      rst_n = 1'b1;
      step();
      checkOutput("post_rst_in_ready", 32'(inReady), 32'd1);

      // ADD 0x7F + 0x01: signed overflow, no carry
      applyStimulus(3'b010, 8'h7F, 8'h01);
      checkAll("add", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("add_in_ready_busy", 32'(inReady), 32'd0);
      step();
      checkOutput("add_drained", 32'(outValid), 32'd0);
      checkOutput("add_ready_back", 32'(inReady), 32'd1);

      // SUB 5 - 5
      applyStimulus(3'b110, 8'h05, 8'h05);
      checkAll("sub", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
      step();

      // SLT -128 < 127 even though the subtraction overflows
      applyStimulus(3'b111, 8'h80, 8'h7F);
      checkAll("slt", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // SLT 127 < -128 is false
      applyStimulus(3'b111, 8'h7F, 8'h80);
      checkAll("slt_false", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
      step();

      // OR and NOR
      applyStimulus(3'b001, 8'hA0, 8'h05);
      checkAll("or", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      applyStimulus(3'b100, 8'hA0, 8'h05);
      checkAll("nor", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // ADD with carry-out and wrap: 0xFF + 0x02
      applyStimulus(3'b010, 8'hFF, 8'h02);
      checkAll("add_wrap", 8'h01, 1'b0, 1'b0, 1'b1, 1'b0);
      step();

      // Backpressure on AND while a second request is waiting
      outReady = 1'b0;
      applyStimulus(3'b000, 8'hF0, 8'h3C);
      checkAll("and", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
      opIn    = 3'b010;
      aIn     = 8'h11;
      bIn     = 8'h22;
      inValid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checkOutput("bp_valid", 32'(outValid), 32'd1);
         checkOutput("bp_result", 32'(resultOut), 32'h30);
         checkOutput("bp_in_ready", 32'(inReady), 32'd0);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      step();
      checkOutput("bp_drained", 32'(outValid), 32'd0);
      checkOutput("bp_ready_back", 32'(inReady), 32'd1);
      step();
      checkOutput("bp_ignored_req", 32'(outValid), 32'd0);

      // Reserved opcode
      applyStimulus(3'b101, 8'h12, 8'h34);
      checkAll("op101", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      step();

`ifdef ALU_SEQ_MUL_EN
      // MUL 0x0F * 0x11 = 0xFF, result WIDTH+1 cycles after accept
      applyStimulus(3'b011, 8'h0F, 8'h11);
      checkOutput("mul_busy", 32'(inReady), 32'd0);
      cycles = 1;
      while (!outValid && cycles < 20) begin
         step();
         cycles++;
      end
      checkOutput("mul_latency", 32'(cycles), 32'd9);
      checkAll("mul1", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
      step();

      // MUL 0x10 * 0x10 = 0x100: low half zero, high half set
      applyStimulus(3'b011, 8'h10, 8'h10);
      cycles = 1;
      while (!outValid && cycles < 20) begin
         step();
         cycles++;
      end
      checkOutput("mul2_latency", 32'(cycles), 32'd9);
      checkAll("mul2", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
      step();

      // Reset during the fourth MUL cycle drops the operation
      applyStimulus(3'b011, 8'h03, 8'h05);
      repeat (3) step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checkOutput("mulrst_valid", 32'(outValid), 32'd0);
      checkOutput("mulrst_in_ready", 32'(inReady), 32'd0);
      checkOutput("mulrst_result", 32'(resultOut), 32'd0);
      checkOutput("mulrst_flags", 32'({zeroOut, ovfOut, carryOut, illegalOut}), 32'd0);
      step();
      checkOutput("mulrst_ready_back", 32'(inReady), 32'd1);
      sawStale = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (outValid) sawStale = 1'b1;
      end
      checkOutput("mulrst_no_stale", 32'(sawStale), 32'd0);
`else
      // Without the multiplier, opcode 011 is illegal
      applyStimulus(3'b011, 8'h0F, 8'h11);
      checkAll("op011", 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
      step();
`endif

      // Reset while holding a result in DONE
      outReady = 1'b0;
      applyStimulus(3'b010, 8'h01, 8'h01);
      checkAll("done_pre_rst", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checkOutput("donerst_valid", 32'(outValid), 32'd0);
      checkOutput("donerst_result", 32'(resultOut), 32'd0);
      checkOutput("donerst_in_ready", 32'(inReady), 32'd0);
      step();
      checkOutput("donerst_ready_back", 32'(inReady), 32'd1);
      checkOutput("donerst_no_stale", 32'(outValid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
